gci_std_display_vram_write_buffer: RTL and testbench
====================================================

# gci_std_display_vram_write_buffer

Posted-write buffer and memory write sequencer between the display command controller and the VRAM device port. Accepts single-pixel writes (19-bit address, 16-bit 5R6G5B data) and queues them in a small FIFO. Replays them to VRAM as fixed-length write strobes, yielding to the scanout reader whenever it owns the memory. Its wait output feeds the command controller's VRAM wait input, so upstream stalls only when the queue is full.

## Interface
- P_DEPTH_N, 4, log2 of FIFO depth (depth = 16 entries)
- P_WE_CYCLES, 2, cycles oMEM_WE is held high per write (>= 1)

- iCLOCK  in  1  system clock; all logic on rising edge
- iRESET_SYNC  in  1  reset, synchronous and active-high
- iWR_REQ  in  1  write request from the command controller
- iWR_ADDR  in  19  pixel address, linear 640x480
- iWR_DATA  in  16  pixel colour, 5R6G5B
- oWR_WAIT  out  1  queue full; a request in this cycle is not accepted
- iMEM_BUSY  in  1  scanout reader owns VRAM; no new write may start
- oMEM_WE  out  1  VRAM write strobe
- oMEM_ADDR  out  19  VRAM address; stable from SETUP through HOLD
- oMEM_DATA  out  16  VRAM write data; stable from SETUP through HOLD
- oEMPTY  out  1  queue empty and sequencer in IDLE
- oCOUNT  out  P_DEPTH_N+1  current queue occupancy
- oDROP  out  1  one-cycle pulse when an out-of-range write is discarded

## Operation
- **Accept.** A write is accepted on any cycle with iWR_REQ=1 and oWR_WAIT=0.
  - If iWR_ADDR < 19'h4B000, {addr, data} is pushed at the tail.
  - If iWR_ADDR >= 19'h4B000, nothing is pushed and oDROP=1 on the next cycle. This covers the clear command's terminal write at 0x4B000.
- **Ignored requests.** A request while oWR_WAIT=1 is ignored. Upstream must hold it.
- **FIFO.** Strict order; no coalescing or reordering.
  - oWR_WAIT is registered and equals (count == 2^P_DEPTH_N).
  - Per cycle, count changes by +1 on push only, -1 on pop only, and is unchanged on push+pop.
- **Sequencer states: IDLE, SETUP, STROBE, HOLD.**
  - IDLE: if count != 0 and iMEM_BUSY=0, pop the head into the oMEM_ADDR/oMEM_DATA registers and go to SETUP. Otherwise stay.
  - SETUP: one cycle with oMEM_WE=0, then go to STROBE.
  - STROBE: oMEM_WE=1 for exactly P_WE_CYCLES cycles (down-counter), then go to HOLD.
  - HOLD: one cycle with oMEM_WE=0 and address/data held.
    - If count != 0 and iMEM_BUSY=0, pop the next entry and go to SETUP.
    - Otherwise go to IDLE. oMEM_ADDR/oMEM_DATA keep their last values.
- **iMEM_BUSY handling.** iMEM_BUSY is sampled only in IDLE and HOLD. A write that has entered SETUP always completes, even if iMEM_BUSY rises.
- **Status outputs.**
  - oEMPTY = (count == 0) && state == IDLE, registered.
  - oCOUNT reflects the registered count.

## Timing
- **Reset values.**
  - State IDLE; pointers and count 0.
  - oWR_WAIT=0, oEMPTY=1, oCOUNT=0, oMEM_WE=0, oMEM_ADDR=0, oMEM_DATA=0, oDROP=0.
- **Reset during a write.** oMEM_WE is 0 in the cycle after iRESET_SYNC is sampled high, and all queued entries are discarded.
- **Single-write latency.** With the write accepted at the edge ending cycle N and iMEM_BUSY=0:
  - Cycle N+1: IDLE, pops the entry.
  - Cycle N+2: SETUP.
  - Cycles N+3 .. N+2+P_WE_CYCLES: oMEM_WE=1.
  - Next cycle: HOLD.
- **Throughput.** One write per (2 + P_WE_CYCLES) cycles, i.e. 4 at the default, back-to-back via HOLD→SETUP.
- **Full boundary.**
  - oWR_WAIT rises the cycle after the 16th push.
  - oWR_WAIT falls the cycle after the first pop from full.
  - A push coinciding with a pop when count=15 leaves count at 15.
- **Empty boundary.** An entry pushed while IDLE with count 0 is popped no earlier than the following cycle; there is no bypass path.

## Test plan
- **Reset.** Assert iRESET_SYNC for 2 cycles → all outputs at their reset values; oEMPTY=1, oCOUNT=0.
- **Single write.** Write addr 0x00123, data 0xF800 with iMEM_BUSY=0 → oMEM_WE high exactly in cycles N+3 and N+4 with oMEM_ADDR=0x00123 and oMEM_DATA=0xF800. Both values stay stable from N+2 to N+5; oEMPTY returns to 1 at N+6.
- **Fill and drain.** Hold iMEM_BUSY=1 and push 17 writes with addresses 0..16 → 16 accepted, oWR_WAIT=1, oCOUNT=16. Release iMEM_BUSY → 16 strobes in address order 0..15, one every 4 cycles. Write 16 is then accepted after oWR_WAIT falls.
- **Busy during a write.** Raise iMEM_BUSY in the SETUP cycle → the current write completes. The next write does not start until iMEM_BUSY=0 is sampled in HOLD or IDLE.
- **Out-of-range address.** Write addr 0x4B000 → oDROP pulses for 1 cycle, oCOUNT is unchanged, and no oMEM_WE is issued. Write addr 0x4AFFF → queued and written normally.
- **Reset mid-operation.** Assert iRESET_SYNC in the second STROBE cycle with 5 entries queued → oMEM_WE=0 in the next cycle, oCOUNT=0, and no further strobes.

Source files
------------

// File: rtl/gci_std_display_vram_write_buffer.sv
// Posted-write FIFO between the display command controller and VRAM.
// Replays queued pixel writes as SETUP / STROBE / HOLD sequences, yielding to scanout.
module gci_std_display_vram_write_buffer #(
  parameter int P_DEPTH_N   = 4,
  parameter int P_WE_CYCLES = 2
)(
  input  logic                 iCLOCK,
  input  logic                 iRESET_SYNC,
  input  logic                 iWR_REQ,
  input  logic [18:0]          iWR_ADDR,
  input  logic [15:0]          iWR_DATA,
  output logic                 oWR_WAIT,
  input  logic                 iMEM_BUSY,
  output logic                 oMEM_WE,
  output logic [18:0]          oMEM_ADDR,
  output logic [15:0]          oMEM_DATA,
  output logic                 oEMPTY,
  output logic [P_DEPTH_N:0]   oCOUNT,
  output logic                 oDROP
);

  localparam int DEPTH = 1 << P_DEPTH_N;
  localparam int WE_W  = (P_WE_CYCLES > 1) ? $clog2(P_WE_CYCLES) : 1;

  localparam logic [P_DEPTH_N:0]   FULL_C       = (P_DEPTH_N+1)'(DEPTH);
  localparam logic [P_DEPTH_N:0]   CNT_ZERO_C   = (P_DEPTH_N+1)'(0);
  localparam logic [P_DEPTH_N-1:0] PTR_ZERO_C   = P_DEPTH_N'(0);
  localparam logic [P_DEPTH_N-1:0] PTR_ONE_C    = P_DEPTH_N'(1);
  localparam logic [WE_W-1:0]      WE_LOAD_C    = WE_W'(P_WE_CYCLES - 1);
  localparam logic [WE_W-1:0]      WE_ZERO_C    = WE_W'(0);
  localparam logic [WE_W-1:0]      WE_ONE_C     = WE_W'(1);
  // First address past the 640x480 frame; the clear command's terminal write lands here.
  localparam logic [18:0]          ADDR_LIMIT_C = 19'h4B000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [34:0]          mem_r [DEPTH];
  logic [P_DEPTH_N-1:0] wr_ptr_r;
  logic [P_DEPTH_N-1:0] rd_ptr_r;
  logic [P_DEPTH_N:0]   count_r;
  logic [P_DEPTH_N:0]   count_next_s;
  logic [WE_W-1:0]      we_cnt_r;
  logic                 wait_r;
  logic                 empty_r;
  logic                 drop_r;
  logic                 we_r;
  logic [18:0]          addr_r;
  logic [15:0]          data_r;
  logic                 accept_s;
  logic                 in_range_s;
  logic                 push_s;
  logic                 pop_s;

  assign accept_s     = iWR_REQ & ~wait_r;
  assign in_range_s   = (iWR_ADDR < ADDR_LIMIT_C);
  assign push_s       = accept_s & in_range_s;
  assign count_next_s = count_r + {{P_DEPTH_N{1'b0}}, push_s} - {{P_DEPTH_N{1'b0}}, pop_s};

  // Sequencer state register.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and pop decision; scanout ownership is only honoured between writes.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if ((count_r != CNT_ZERO_C) && !iMEM_BUSY) begin
          pop_s        = 1'b1;
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_next_s = ST_STROBE;
      end
      ST_STROBE: begin
        if (we_cnt_r == WE_ZERO_C) begin
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_STROBE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge iCLOCK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {iWR_ADDR, iWR_DATA};
    end
  end

  // Queue bookkeeping, memory-port registers and status flags.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
      we_cnt_r <= WE_ZERO_C;
      wait_r   <= 1'b0;
      empty_r  <= 1'b1;
      drop_r   <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= 19'h00000;
      data_r   <= 16'h0000;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        {addr_r, data_r} <= mem_r[rd_ptr_r];
        rd_ptr_r         <= rd_ptr_r + PTR_ONE_C;
      end
      if (state_r == ST_SETUP) begin
        we_cnt_r <= WE_LOAD_C;
      end else if ((state_r == ST_STROBE) && (we_cnt_r != WE_ZERO_C)) begin
        we_cnt_r <= we_cnt_r - WE_ONE_C;
      end
      count_r <= count_next_s;
      wait_r  <= (count_next_s == FULL_C);
      empty_r <= (count_next_s == CNT_ZERO_C) && (state_next_s == ST_IDLE);
      drop_r  <= accept_s & ~in_range_s;
      we_r    <= (state_next_s == ST_STROBE);
    end
  end

  assign oWR_WAIT  = wait_r;
  assign oMEM_WE   = we_r;
  assign oMEM_ADDR = addr_r;
  assign oMEM_DATA = data_r;
  assign oEMPTY    = empty_r;
  assign oCOUNT    = count_r;
  assign oDROP     = drop_r;

endmodule

// File: tb/tb_gci_std_display_vram_write_buffer.sv
// Scoreboard bench: accepted in-range writes are queued as expectations; a
// negedge monitor pops them as VRAM strobes appear and checks content, length and timing.
module tb_gci_std_display_vram_write_buffer;

  localparam int P_DEPTH_N   = 4;
  localparam int P_WE_CYCLES = 2;
  localparam int DEPTH       = 16;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iWR_REQ;
  logic [18:0] iWR_ADDR;
  logic [15:0] iWR_DATA;
  logic        oWR_WAIT;
  logic        iMEM_BUSY;
  logic        oMEM_WE;
  logic [18:0] oMEM_ADDR;
  logic [15:0] oMEM_DATA;
  logic        oEMPTY;
  logic [4:0]  oCOUNT;
  logic        oDROP;

  gci_std_display_vram_write_buffer #(
    .P_DEPTH_N  (P_DEPTH_N),
    .P_WE_CYCLES(P_WE_CYCLES)
  ) dut (
    .iCLOCK     (iCLOCK),
    .iRESET_SYNC(iRESET_SYNC),
    .iWR_REQ    (iWR_REQ),
    .iWR_ADDR   (iWR_ADDR),
    .iWR_DATA   (iWR_DATA),
    .oWR_WAIT   (oWR_WAIT),
    .iMEM_BUSY  (iMEM_BUSY),
    .oMEM_WE    (oMEM_WE),
    .oMEM_ADDR  (oMEM_ADDR),
    .oMEM_DATA  (oMEM_DATA),
    .oEMPTY     (oEMPTY),
    .oCOUNT     (oCOUNT),
    .oDROP      (oDROP)
  );

  always #5 iCLOCK = ~iCLOCK;

  int cyc = 0;
  always @(posedge iCLOCK) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [34:0] exp_q[$];
  int          starts_q[$];
  bit          rand_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
    if (rand_busy) iMEM_BUSY = ($urandom_range(0, 3) == 0);
  endtask

  // Present one write, hold it while oWR_WAIT is high, return the acceptance cycle.
  task automatic send(input logic [18:0] a, input logic [15:0] d, output int acc_cyc);
    iWR_REQ  = 1'b1;
    iWR_ADDR = a;
    iWR_DATA = d;
    for (int k = 0; k < 400 && oWR_WAIT; k++) tick();
    if (oWR_WAIT) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got wait=1 expected wait=0 within budget");
    end
    acc_cyc = cyc;
    if (a < 19'h4B000) exp_q.push_back({a, d});
    tick();
    iWR_REQ = 1'b0;
    chk("drop_flag", oDROP, (a >= 19'h4B000));
  endtask

  task automatic wait_empty(input int budget);
    for (int k = 0; k < budget && !oEMPTY; k++) tick();
    chk("drain_done", oEMPTY, 1'b1);
  endtask

  // Monitor: every strobe must match the oldest outstanding accepted write.
  initial begin : monitor
    logic        prev_we = 1'b0;
    bit          tracking = 1'b0;
    int          we_len = 0;
    logic [34:0] cap;
    logic [34:0] e;
    forever begin
      @(negedge iCLOCK);
      if (iRESET_SYNC) begin
        tracking = 1'b0;
      end else if (oMEM_WE && !prev_we) begin
        starts_q.push_back(cyc);
        tracking = 1'b1;
        we_len   = 1;
        cap      = {oMEM_ADDR, oMEM_DATA};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got addr %0h expected no write", oMEM_ADDR);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", oMEM_ADDR, e[34:16]);
          chk("wr_data", oMEM_DATA, e[15:0]);
        end
      end else if (oMEM_WE && tracking) begin
        we_len++;
        chk("strobe_stable", {oMEM_ADDR, oMEM_DATA}, cap);
      end else if (!oMEM_WE && prev_we && tracking) begin
        chk("strobe_len", we_len, P_WE_CYCLES);
        chk("hold_stable", {oMEM_ADDR, oMEM_DATA}, cap);
        tracking = 1'b0;
      end
      prev_we = oMEM_WE;
    end
  end

  initial begin : stim
    int          n;
    int          m;
    int          r;
    logic [15:0] d16;
    logic [18:0] a;

    iRESET_SYNC = 1'b1;
    iWR_REQ     = 1'b0;
    iWR_ADDR    = 19'h00000;
    iWR_DATA    = 16'h0000;
    iMEM_BUSY   = 1'b0;
    tick();
    tick();
    chk("rst_wait",  oWR_WAIT,  1'b0);
    chk("rst_empty", oEMPTY,    1'b1);
    chk("rst_count", oCOUNT,    5'd0);
    chk("rst_we",    oMEM_WE,   1'b0);
    chk("rst_addr",  oMEM_ADDR, 19'h0);
    chk("rst_data",  oMEM_DATA, 16'h0);
    chk("rst_drop",  oDROP,     1'b0);
    iRESET_SYNC = 1'b0;
    tick();

    // Single write: strobe in N+3..N+4, idle again at N+6.
    starts_q.delete();
    send(19'h00123, 16'hF800, n);
    for (int k = 1; k <= 6; k++) begin
      chk("single_we", oMEM_WE, (k == 3 || k == 4));
      if (k >= 2 && k <= 5) begin
        chk("single_addr", oMEM_ADDR, 19'h00123);
        chk("single_data", oMEM_DATA, 16'hF800);
      end
      chk("single_empty", oEMPTY, (k == 6));
      tick();
    end
    chk("single_nstrobes", starts_q.size(), 1);
    if (starts_q.size() >= 1) chk("single_latency", starts_q[0], n + 3);

    // Fill while busy, then drain in order at one write per four cycles.
    iMEM_BUSY = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_wait_low", oWR_WAIT, 1'b0);
      iWR_REQ  = 1'b1;
      iWR_ADDR = 19'(i);
      iWR_DATA = 16'($urandom);
      exp_q.push_back({iWR_ADDR, iWR_DATA});
      tick();
    end
    chk("full_wait", oWR_WAIT, 1'b1);
    chk("full_count", oCOUNT, 5'd16);
    d16      = 16'($urandom);
    iWR_ADDR = 19'd16;
    iWR_DATA = d16;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full_ignored_count", oCOUNT, 5'd16);
      chk("full_ignored_wait", oWR_WAIT, 1'b1);
    end
    starts_q.delete();
    iMEM_BUSY = 1'b0;
    m = cyc;
    tick();
    chk("wait_falls", oWR_WAIT, 1'b0);
    chk("count_after_pop", oCOUNT, 5'd15);
    exp_q.push_back({19'd16, d16});
    tick();
    iWR_REQ = 1'b0;
    chk("refill_count", oCOUNT, 5'd16);
    chk("refill_wait", oWR_WAIT, 1'b1);
    wait_empty(300);
    chk("drain_nstrobes", starts_q.size(), DEPTH + 1);
    if (starts_q.size() == DEPTH + 1) begin
      chk("drain_first", starts_q[0], m + 2);
      for (int i = 1; i <= DEPTH; i++) chk("drain_cadence", starts_q[i] - starts_q[i-1], 4);
    end
    chk("drain_count", oCOUNT, 5'd0);

    // Busy raised in SETUP: current write completes, next waits for release.
    starts_q.delete();
    send(19'h01000, 16'h07E0, n);
    send(19'h01001, 16'h001F, r);
    iMEM_BUSY = 1'b1;
    repeat (8) tick();
    chk("busy_held_we", oMEM_WE, 1'b0);
    r = cyc;
    iMEM_BUSY = 1'b0;
    wait_empty(50);
    chk("busy_nstrobes", starts_q.size(), 2);
    if (starts_q.size() == 2) begin
      chk("busy_first", starts_q[0], n + 3);
      chk("busy_second", starts_q[1], r + 2);
    end

    // Out-of-range writes are dropped; the last in-range address is written.
    starts_q.delete();
    send(19'h4B000, 16'hFFFF, n);
    chk("drop_count", oCOUNT, 5'd0);
    tick();
    chk("drop_pulse_end", oDROP, 1'b0);
    send(19'h7FFFF, 16'h1234, n);
    repeat (8) tick();
    chk("drop_nstrobes", starts_q.size(), 0);
    send(19'h4AFFF, 16'hABCD, n);
    wait_empty(50);
    chk("edge_nstrobes", starts_q.size(), 1);

    // Randomized traffic with random scanout contention.
    rand_busy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      chk("wait_vs_count", oWR_WAIT, (oCOUNT == 5'd16));
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 7) == 0) a = 19'($urandom_range(32'h4B000, 32'h7FFFF));
        else a = 19'($urandom_range(0, 32'h4AFFF));
        send(a, 16'($urandom), n);
      end else begin
        tick();
      end
    end
    rand_busy = 1'b0;
    iMEM_BUSY = 1'b0;
    wait_empty(2000);
    chk("rand_outstanding", exp_q.size(), 0);
    chk("rand_count", oCOUNT, 5'd0);

    // Reset in the second strobe cycle with five entries still queued.
    iMEM_BUSY = 1'b1;
    for (int i = 0; i < 6; i++) send(19'($urandom_range(0, 32'h4AFFF)), 16'($urandom), n);
    iMEM_BUSY = 1'b0;
    for (int k = 0; k < 20 && !oMEM_WE; k++) tick();
    chk("mid_we_started", oMEM_WE, 1'b1);
    tick();
    chk("mid_second_strobe", oMEM_WE, 1'b1);
    chk("mid_count", oCOUNT, 5'd5);
    iRESET_SYNC = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_we", oMEM_WE, 1'b0);
    chk("mid_rst_count", oCOUNT, 5'd0);
    chk("mid_rst_empty", oEMPTY, 1'b1);
    iRESET_SYNC = 1'b0;
    starts_q.delete();
    repeat (30) tick();
    chk("mid_no_strobes", starts_q.size(), 0);
    chk("mid_final_we", oMEM_WE, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
